// File: rtl/ro_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Holds the FSM state type, data_out byte selectors, status bit positions and config field layout.
package ro_freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2
    } state_t;

    localparam logic [1:0] BSEL_LO   = 2'd0;
    localparam logic [1:0] BSEL_HI   = 2'd1;
    localparam logic [1:0] BSEL_STAT = 2'd2;
    localparam logic [1:0] BSEL_RND  = 2'd3;

    localparam int STAT_BUSY  = 7;
    localparam int STAT_VALID = 6;
    localparam int STAT_OVF   = 5;
    localparam int STAT_CONT  = 4;

    // Config word, LSB first: window, channel, continuous flag.
    function automatic int cfg_win_lsb();
        return 0;
    endfunction

    function automatic int cfg_sel_lsb(input int win_w);
        return win_w;
    endfunction

    function automatic int cfg_cont_pos(input int sel_w, input int win_w);
        return sel_w + win_w;
    endfunction

    function automatic int cfg_base_width(input int sel_w, input int win_w);
        return 1 + sel_w + win_w;
    endfunction

endpackage

// File: rtl/ro_freq_meter_sync.sv
// Multi-bit, multi-stage synchroniser bringing asynchronous inputs into the clk domain.
// Each bit is synchronised independently; no cross-bit coherency is implied.
module ro_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stg;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg <= {stg[DEPTH-2:0], d};
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/ro_freq_meter.sv
// Frequency meter: counts rising edges of one synchronised oscillator over a gate window of clk cycles.
// Optional macro RO_FREQ_METER_RANDOM_EN adds a masked-XOR random byte readable on byte_sel=3.
module ro_freq_meter
    import ro_freq_meter_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SEL_W       = 3,
    parameter int WIN_W       = 12,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  osc_in,
    input  logic             cfg_shift,
    input  logic             cfg_dta,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       byte_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic [7:0]       data_out
);

    localparam int CFG_BASE_W = cfg_base_width(SEL_W, WIN_W);
`ifdef RO_FREQ_METER_RANDOM_EN
    localparam int CFG_W = CFG_BASE_W + N_CH;
`else
    localparam int CFG_W = CFG_BASE_W;
`endif
    localparam int WIN_LSB  = cfg_win_lsb();
    localparam int SEL_LSB  = cfg_sel_lsb(WIN_W);
    localparam int CONT_POS = cfg_cont_pos(SEL_W, WIN_W);
    localparam int ST_W     = $clog2(SYNC_STAGES + 1) + 1;

    state_t           state, state_n;
    logic             start_meas, gate_last;

    logic [CFG_W-1:0] cfg_sr;
    logic [WIN_W-1:0] cfg_win;
    logic [SEL_W-1:0] cfg_ch;
    logic             cfg_cont;

    logic [SEL_W-1:0] active_ch;
    logic [WIN_W-1:0] active_win;
    logic             active_cont;

    logic [WIN_W-1:0] win_cnt;
    logic [ST_W-1:0]  settle_cnt;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             sat_hit, sat_seen;
    logic             ovf, valid, cont_active;

    logic [N_CH-1:0]  osc_sync;
    logic             cur, prev, rise;

    logic [15:0]      res_ext;
    logic [7:0]       stat_byte, rnd_out;

    // Config shift register; free to shift at any time, only sampled on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_sr <= '0;
        end else if (cfg_shift) begin
            cfg_sr <= {cfg_sr[CFG_W-2:0], cfg_dta};
        end
    end

    assign cfg_win  = cfg_sr[WIN_LSB +: WIN_W];
    assign cfg_ch   = cfg_sr[SEL_LSB +: SEL_W];
    assign cfg_cont = cfg_sr[CONT_POS];

    ro_sync #(
        .WIDTH (N_CH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (osc_in),
        .q     (osc_sync)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cur = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (active_ch == SEL_W'(i)) begin
                cur = osc_sync[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= cur;
        end
    end

    assign rise    = cur & ~prev;
    assign sat_hit = rise && (cnt == '1);
    assign cnt_inc = (rise && !sat_hit) ? cnt + CNT_W'(1) : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // stop outranks both start and window completion.
    always_comb begin
        state_n    = state;
        start_meas = 1'b0;
        gate_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n    = SETTLE;
                    start_meas = 1'b1;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (settle_cnt == '0) begin
                    state_n = GATE;
                end
            end
            GATE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (win_cnt == '0) begin
                    gate_last = 1'b1;
                    state_n   = active_cont ? GATE : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Window counter loads W-1; W=0 wraps to all-ones, giving 2^WIN_W gate cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_ch   <= '0;
            active_win  <= '0;
            active_cont <= 1'b0;
            win_cnt     <= '0;
            settle_cnt  <= '0;
            cnt         <= '0;
            sat_seen    <= 1'b0;
            result      <= '0;
            ovf         <= 1'b0;
            valid       <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_meas) begin
                active_ch   <= cfg_ch;
                active_win  <= cfg_win;
                active_cont <= cfg_cont;
                win_cnt     <= cfg_win - WIN_W'(1);
                settle_cnt  <= ST_W'(SYNC_STAGES);
                cnt         <= '0;
                sat_seen    <= 1'b0;
                valid       <= 1'b0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - ST_W'(1);
            end else if (state == GATE && !stop) begin
                if (gate_last) begin
                    result   <= cnt_inc;
                    ovf      <= sat_seen | sat_hit;
                    valid    <= 1'b1;
                    done     <= 1'b1;
                    cnt      <= '0;
                    sat_seen <= 1'b0;
                    win_cnt  <= active_win - WIN_W'(1);
                end else begin
                    cnt      <= cnt_inc;
                    sat_seen <= sat_seen | sat_hit;
                    win_cnt  <= win_cnt - WIN_W'(1);
                end
            end
        end
    end

    assign busy        = (state != IDLE);
    assign cont_active = active_cont & busy;

`ifdef RO_FREQ_METER_RANDOM_EN
    logic [N_CH-1:0] rnd_mask;
    logic            rnd_bit;
    logic [7:0]      rnd_byte;

    assign rnd_mask = cfg_sr[CFG_W-1 -: N_CH];
    assign rnd_bit  = ^(osc_sync & rnd_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_byte <= '0;
        end else begin
            rnd_byte <= {rnd_byte[6:0], rnd_bit};
        end
    end

    assign rnd_out = rnd_byte;
`else
    assign rnd_out = 8'h00;
`endif

    always_comb begin
        res_ext               = 16'(result);
        stat_byte             = '0;
        stat_byte[STAT_BUSY]  = busy;
        stat_byte[STAT_VALID] = valid;
        stat_byte[STAT_OVF]   = ovf;
        stat_byte[STAT_CONT]  = cont_active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            unique case (byte_sel)
                BSEL_LO:   data_out <= res_ext[7:0];
                BSEL_HI:   data_out <= res_ext[15:8];
                BSEL_STAT: data_out <= stat_byte;
                default:   data_out <= rnd_out;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter: oscillators driven from an edge log that feeds a window-count model.
module tb_ro_freq_meter;
    import ro_freq_meter_pkg::*;

    localparam int N_CH  = 6;
    localparam int SEL_W = 3;
    localparam int WIN_W = 12;
    localparam int CNT_W = 10;
    localparam int SYNC  = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef RO_FREQ_METER_RANDOM_EN
    localparam int CFG_W = 1 + SEL_W + WIN_W + N_CH;
`else
    localparam int CFG_W = 1 + SEL_W + WIN_W;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  osc_in = '0;
    logic             cfg_shift = 1'b0;
    logic             cfg_dta = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [1:0]       byte_sel = 2'd0;
    logic             busy, done;
    logic [CNT_W-1:0] result;
    logic [7:0]       data_out;

    int cyc = 0;
    int hp[N_CH];
    int ph[N_CH];
    int rise_q[N_CH][$];
    int n_checks = 0;
    int n_errors = 0;
    int last_result = 0;
    bit last_ovf = 1'b0;

    ro_freq_meter #(
        .N_CH(N_CH), .SEL_W(SEL_W), .WIN_W(WIN_W), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .cfg_shift(cfg_shift), .cfg_dta(cfg_dta),
        .start(start), .stop(stop), .byte_sel(byte_sel), .busy(busy), .done(done),
        .result(result), .data_out(data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Square waves of hp[i] cycles per half period; each rise is logged with the posedge that first samples it.
    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (hp[i] != 0) begin
                if (ph[i] + 1 >= hp[i]) begin
                    ph[i] <= 0;
                    osc_in[i] <= ~osc_in[i];
                    if (!osc_in[i]) rise_q[i].push_back(cyc + 1);
                end else begin
                    ph[i] <= ph[i] + 1;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A rise sampled at posedge e is counted at posedge e+SYNC; the gate counts posedges lo..hi.
    function automatic int count_rises(input int ch, input int lo, input int hi);
        int n = 0;
        if (ch >= N_CH) return 0;
        for (int i = 0; i < rise_q[ch].size(); i++) begin
            if (rise_q[ch][i] + SYNC >= lo && rise_q[ch][i] + SYNC <= hi) n++;
        end
        return n;
    endfunction

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic shift_cfg(input bit cont, input int ch, input int win, input int mask);
        logic [63:0] w;
        w = (64'(mask) << (1 + SEL_W + WIN_W)) | (64'(cont) << (SEL_W + WIN_W))
          | (64'(ch & ((1 << SEL_W) - 1)) << WIN_W) | 64'(win & ((1 << WIN_W) - 1));
        for (int i = CFG_W - 1; i >= 0; i--) begin
            @(negedge clk);
            cfg_shift = 1'b1;
            cfg_dta   = w[i];
        end
        @(negedge clk);
        cfg_shift = 1'b0;
        cfg_dta   = 1'b0;
    endtask

    // Returns at the negedge right after the posedge (p0) that sampled start.
    task automatic do_start(output int p0);
        @(negedge clk);
        start = 1'b1;
        p0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    task automatic read_byte(input logic [1:0] sel, output logic [7:0] b);
        @(negedge clk);
        byte_sel = sel;
        @(negedge clk);
        b = data_out;
    endtask

    task automatic meas_single(input string tag, input int ch, input int w);
        int weff, p0, dc, exp, extra;
        bit ok;
        logic [7:0] b;
        weff = (w == 0) ? (1 << WIN_W) : w;
        do_start(p0);
        check({tag, "_busy"}, busy, 1);
        wait_done(weff + SYNC + 20, dc, ok);
        check({tag, "_done"}, ok, 1);
        check({tag, "_lat"}, dc, p0 + SYNC + 1 + weff);
        exp = count_rises(ch, p0 + SYNC + 2, p0 + SYNC + 1 + weff);
        check({tag, "_res"}, result, sat(exp));
        check({tag, "_idle"}, busy, 0);
        last_result = sat(exp);
        last_ovf = (exp > CMAX);
        count_done(6, extra);
        check({tag, "_once"}, extra, 0);
        read_byte(BSEL_STAT, b);
        check({tag, "_stat"}, b, {2'b01, last_ovf, 5'b0});
    endtask

    initial begin
        int p0, dc, exp, extra, sum, ch, w;
        bit ok, ovf_pre;
        logic [7:0] b;

        hp = '{3, 5, 4, 7, 2, 6};
        ph = '{0, 0, 0, 0, 0, 0};
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_data", data_out, 0);
        rst_n = 1'b1;
        read_byte(BSEL_STAT, b);
        check("rst_stat", b, 0);

        // Single shot, ch2 at period 8 over 64 cycles.
        shift_cfg(0, 2, 64, 0);
        meas_single("single", 2, 64);

        // Saturation: ch0 at period 2 for 4000 cycles exceeds the counter range.
        hp[0] = 1;
        shift_cfg(0, 0, 4000, 0);
        meas_single("ovf", 0, 4000);
        read_byte(BSEL_LO, b);
        check("ovf_lo", b, 8'hFF);
        read_byte(BSEL_HI, b);
        check("ovf_hi", b, 8'h03);

        // Continuous: five back-to-back windows on ch1 (period 10).
        hp[1] = 5;
        shift_cfg(1, 1, 100, 0);
        byte_sel = BSEL_STAT;
        ovf_pre = last_ovf;
        do_start(p0);
        sum = 0;
        for (int k = 0; k < 5; k++) begin
            wait_done(130, dc, ok);
            check("cont_done", ok, 1);
            check("cont_lat", dc, p0 + SYNC + 1 + (k + 1) * 100);
            exp = count_rises(1, p0 + SYNC + 2 + k * 100, p0 + SYNC + 1 + (k + 1) * 100);
            check("cont_res", result, sat(exp));
            check("cont_stat", data_out, 8'h90 | ((k > 0) ? 8'h40 : 8'h00) | (ovf_pre ? 8'h20 : 8'h00));
            check("cont_busy", busy, 1);
            sum += int'(result);
            ovf_pre = (exp > CMAX);
            last_result = sat(exp);
        end
        check("cont_sum", sum, count_rises(1, p0 + SYNC + 2, p0 + SYNC + 1 + 500));
        last_ovf = ovf_pre;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("cont_stop_busy", busy, 0);
        count_done(110, extra);
        check("cont_stop_nodone", extra, 0);
        check("cont_stop_res", result, last_result);

        // Abort at gate cycle 30.
        shift_cfg(0, 3, 100, 0);
        do_start(p0);
        while (cyc < p0 + SYNC + 1 + 30) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("abort_busy", busy, 0);
        count_done(120, extra);
        check("abort_nodone", extra, 0);
        check("abort_res", result, last_result);
        read_byte(BSEL_STAT, b);
        check("abort_stat", b, {2'b00, last_ovf, 5'b0});

        // start while busy is ignored.
        shift_cfg(0, 4, 80, 0);
        do_start(p0);
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(80, dc, ok);
        check("bstart_done", ok, 1);
        check("bstart_lat", dc, p0 + SYNC + 1 + 80);
        exp = count_rises(4, p0 + SYNC + 2, p0 + SYNC + 1 + 80);
        check("bstart_res", result, sat(exp));
        last_result = sat(exp);
        last_ovf = (exp > CMAX);
        count_done(12, extra);
        check("bstart_nodone", extra, 0);

        // start together with stop in IDLE starts nothing.
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check("ss_busy", busy, 0);

        // Reconfiguring mid-window leaves the running window alone.
        shift_cfg(0, 1, 200, 0);
        do_start(p0);
        repeat (10) @(negedge clk);
        shift_cfg(0, 5, 150, 0);
        wait_done(250, dc, ok);
        check("iso_done", ok, 1);
        check("iso_lat", dc, p0 + SYNC + 1 + 200);
        exp = count_rises(1, p0 + SYNC + 2, p0 + SYNC + 1 + 200);
        check("iso_res", result, sat(exp));
        meas_single("iso_ch5", 5, 150);
        shift_cfg(0, 7, 50, 0);
        meas_single("inv_ch7", 7, 50);

        // W=0 means a full 2^WIN_W window; also exercises the high byte.
        shift_cfg(0, 3, 0, 0);
        meas_single("w0", 3, 0);
        read_byte(BSEL_HI, b);
        check("w0_hi", b, 8'((last_result >> 8) & 8'hFF));

        // Randomised periods, channels and windows.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N_CH; i++) hp[i] = $urandom_range(0, 6);
            ch = $urandom_range(0, 7);
            w = $urandom_range(16, 300);
            shift_cfg(0, ch, w, 0);
            meas_single("rnd", ch, w);
        end

        // Asynchronous reset in the middle of a gate window.
        hp[2] = 3;
        shift_cfg(0, 2, 200, 0);
        do_start(p0);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check("areset_res", result, 0);
        check("areset_data", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_result = 0;
        last_ovf = 1'b0;
        read_byte(BSEL_STAT, b);
        check("areset_stat", b, 0);

`ifdef RO_FREQ_METER_RANDOM_EN
        read_byte(BSEL_RND, b);
        check("rnd_mask0", b, 0);
        hp[1] = 2;
        shift_cfg(0, 0, 10, 6'b000010);
        repeat (12) @(negedge clk);
        read_byte(BSEL_RND, b);
        check("rnd_masked", (b != 8'h00), 1);
`else
        read_byte(BSEL_RND, b);
        check("rnd_off", b, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Parametrised, single-clock frequency meter for the ring-oscillator test array. It synchronises N_CH free-running oscillator/divider outputs into `clk`, selects one channel, and counts its rising edges over a programmable gate window of `clk` cycles. It supports single-shot and continuous measurement. The result is presented byte-wise on an 8-bit output bus for the pin-limited top level. Configuration is loaded serially through a `clk`-domain shift register, replacing free-running counters on the selected clock.

## Interface
- `N_CH`, 8: number of oscillator inputs.
- `SEL_W`, 3: channel-select width; must satisfy 2^SEL_W >= N_CH.
- `WIN_W`, 12: gate-window field width.
- `CNT_W`, 16: edge-counter and result width; range 8..16.
- `SYNC_STAGES`, 2: synchroniser depth; minimum 2.
- `clk` in 1: the only clock; everything is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `osc_in` in N_CH: asynchronous oscillator inputs; each must run below f_clk/2 (pre-divided upstream).
- `cfg_shift` in 1: shift enable for the config register.
- `cfg_dta` in 1: serial config data, MSB first.
- `start` in 1: starts a measurement; honoured only in IDLE.
- `stop` in 1: synchronous abort.
- `byte_sel` in 2: selects which byte drives `data_out`.
- `busy` out 1: high whenever state != IDLE.
- `done` out 1: one-cycle pulse when a new result is written.
- `result` out CNT_W: last completed count.
- `data_out` out 8: byte view of the result and status.

## Operation
- **Config register.** CFG_W = 1 + SEL_W + WIN_W bits. When `cfg_shift` is high: cfg_sr <= {cfg_sr[CFG_W-2:0], cfg_dta}. Shifting is allowed at any time.
- **Config fields.** [WIN_W-1:0] = window W. Next SEL_W bits = channel. Top bit = continuous.
- **Latching.** The fields are copied into the active config only on an accepted `start`. Shifting mid-measurement never affects the running window.
- **Window length.** W = 0 means 2^WIN_W cycles.
- **Invalid channel.** A channel >= N_CH reads constant 0, giving result 0.
- **Input path.** All `osc_in` bits pass through SYNC_STAGES flops, then the mux, then a prev-sample flop. edge = cur & ~prev.
- **FSM states:** IDLE, SETTLE, GATE.
  - IDLE: on `start`, latch config, clear the counter and `valid`, go to SETTLE.
  - SETTLE: lasts SYNC_STAGES+1 cycles with edges ignored, so the pipeline carries only the new channel. Then go to GATE.
  - GATE: lasts W cycles. Each cycle cnt <= sat(cnt + edge).
  - End of GATE, last cycle: result <= sat(cnt + edge). `ovf` <= 1 if saturation occurred during the window. `valid` <= 1.
  - After the last GATE cycle: single-shot returns to IDLE. Continuous re-enters GATE with cnt = 0 and no gap cycle, so no edge is lost or double-counted.
- **Saturation.** The counter holds at all-ones and never wraps.
- **`stop`.** Sending `stop` in SETTLE or GATE goes to IDLE next cycle. `done` does not pulse; `result`, `ovf` and `valid` keep their previous values. `stop` has priority over window completion in the same cycle.
- **Ignored inputs.** `start` while busy is ignored. `start` and `stop` together in IDLE: stop wins and nothing starts.
- **`data_out` by `byte_sel`:**
  - 0: result[7:0].
  - 1: result[CNT_W-1:8], zero-extended.
  - 2: {busy, valid, ovf, cont_active, 4'b0}.
  - 3: random byte (see Configuration).

## Timing
- **Reset values.** busy=0, done=0, result=0, data_out=0; ovf, valid, cfg_sr, synchronisers all 0; state IDLE.
- **Reset mid-operation.** Immediate return to these values, asynchronously.
- **Single-shot timeline.**
  - `start` sampled at edge t0.
  - busy=1 from t0+1.
  - GATE occupies cycles t0+1+SYNC_STAGES+1 .. +W.
  - `done`=1 and the new `result` appear in the same cycle, the one after the last GATE cycle.
  - busy falls in that same cycle.
- **Continuous.** `done` pulses every W cycles.
- **Measurement latency.** The edge-to-count latency is SYNC_STAGES+1 cycles, constant. The window is therefore shifted but exact in length.
- **`data_out`.** Registered: it reflects `byte_sel` and state one cycle later.

## Configuration
- Macro: `RO_FREQ_METER_RANDOM_EN`.
- **Defined:**
  - An N_CH-bit `rnd_mask` is appended above the top config bit.
  - Each cycle, rnd_bit = XOR of the synchronised samples of the masked channels.
  - rnd_byte <= {rnd_byte[6:0], rnd_bit} every cycle, independent of the FSM.
  - `byte_sel`=3 returns rnd_byte.
- **Undefined:**
  - No mask bits; CFG_W is as above.
  - `byte_sel`=3 returns 8'h00.
  - No extra flops.

## Structure
- **Package `ro_freq_meter_pkg`:**
  - state enum (IDLE, SETTLE, GATE).
  - `byte_sel` constants BSEL_LO, BSEL_HI, BSEL_STAT, BSEL_RND.
  - status bit positions.
  - config field offset/width localparam functions of SEL_W/WIN_W.
- **Sub-module `ro_sync`:** parametrised width/depth synchroniser with asynchronous active-low reset, instantiated once for `osc_in`.

## Test plan
1. **Single-shot.** Reset, shift in ch=2, W=64, single-shot; ch2 toggles every 4 clk (period 8); `start` -> exactly one `done`, result=8, ovf=0, `done` 1+3+64 cycles after `start`, busy low after.
2. **Overflow.** CNT_W=8; ch0 period 2; W=1000 -> result=255, ovf=1, status byte bit5 set.
3. **Continuous.** ch1 period 10, W=100, continuous for 5 windows -> `done` every 100 cycles, each result=10, sum of results = edges driven.
4. **Abort and busy-start.** `stop` at GATE cycle 30 -> IDLE next cycle, no `done`, result holds the prior value. `start` pulsed during GATE -> ignored.
5. **Config isolation.** Re-shift config to ch=5 mid-window -> current result unaffected; the next `start` measures ch5. ch=7 with N_CH=6 -> result=0.
6. **Async reset.** `rst_n` low mid-GATE -> all outputs 0 asynchronously. With `RO_FREQ_METER_RANDOM_EN`: mask=0 -> byte 3 is 0x00; mask on a toggling channel -> byte 3 nonzero.
